// File: rtl/mux8x1_rr_arbiter.sv
// Round-robin arbiter and select controller for an 8:1 single-bit mux with valid/ack handshake.
// Optional per-grant beat limit (HOLD_MAX) is compiled in with `define MUX8X1_ARB_HOLD_EN.
module mux8x1_rr_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] in,
  input  logic       ack,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       result,
  output logic       valid,
  output logic       busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     state_r, state_s;
  logic [2:0] ptr_r, ptr_s;
  logic [2:0] sel_r, sel_s;
  logic [7:0] gnt_r, gnt_s;
  logic [2:0] next_ptr_s;
  logic       any_req_s;
  logic       valid_s;
  logic       hold_s;
  logic       release_s;
  logic       new_grant_s;

  // First requester found scanning p, p+1, ... with 3-bit wrap.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx     = p + 3'(k);
      rr_pick = (!found && r[idx]) ? idx : rr_pick;
      found   = found | r[idx];
    end
  endfunction

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    onehot8 = 8'h01 << idx;
  endfunction

  // Handshake view of the current grant.
  always_comb begin
    valid_s    = (state_r == ST_GRANT) & req[sel_r];
    any_req_s  = |req;
    next_ptr_s = sel_r + 3'd1;
  end

`ifdef MUX8X1_ARB_HOLD_EN
  logic [7:0] cnt_r, cnt_s;
  logic       beat_s;

  // A beat on the last allowed count ends the grant.
  always_comb begin
    beat_s = valid_s & ack;
    hold_s = beat_s & (cnt_r == 8'(HOLD_MAX - 1));
  end
`else
  assign hold_s = 1'b0;
`endif

  assign release_s = ~req[sel_r] | hold_s;

  // Next-state, grant and pointer logic; re-arbitration on release gives zero-bubble handover.
  always_comb begin
    state_s     = state_r;
    sel_s       = sel_r;
    gnt_s       = gnt_r;
    ptr_s       = ptr_r;
    new_grant_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          sel_s       = rr_pick(req, ptr_r);
          gnt_s       = onehot8(rr_pick(req, ptr_r));
          state_s     = ST_GRANT;
          new_grant_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
          gnt_s   = 8'h00;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          ptr_s = next_ptr_s;
          if (any_req_s) begin
            sel_s       = rr_pick(req, next_ptr_s);
            gnt_s       = onehot8(rr_pick(req, next_ptr_s));
            state_s     = ST_GRANT;
            new_grant_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
            gnt_s   = 8'h00;
          end
        end else begin
          state_s = ST_GRANT;
        end
      end
      default: begin
        state_s = ST_IDLE;
        gnt_s   = 8'h00;
        sel_s   = 3'd0;
        ptr_s   = 3'd0;
      end
    endcase
  end

`ifdef MUX8X1_ARB_HOLD_EN
  // Beat counter restarts on every new grant and freezes while no beat occurs.
  always_comb begin
    if (new_grant_s || (state_s == ST_IDLE)) begin
      cnt_s = 8'd0;
    end else if (beat_s) begin
      cnt_s = cnt_r + 8'd1;
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Beat counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= 8'd0;
    end else begin
      cnt_r <= cnt_s;
    end
  end
`endif

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      sel_r   <= 3'd0;
      gnt_r   <= 8'h00;
      ptr_r   <= 3'd0;
    end else begin
      state_r <= state_s;
      sel_r   <= sel_s;
      gnt_r   <= gnt_s;
      ptr_r   <= ptr_s;
    end
  end

  assign gnt    = gnt_r;
  assign sel    = sel_r;
  assign busy   = (state_r == ST_GRANT);
  assign valid  = valid_s;
  assign result = valid_s & in[sel_r];

  mux8x1_rr_arbiter_chk #(
    .HOLD_MAX(HOLD_MAX)
  ) u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .in     (in),
    .ack    (ack),
    .gnt    (gnt_r),
    .sel    (sel_r),
    .result (result),
    .valid  (valid_s),
    .busy   (busy)
  );

endmodule

// Invariant checker for the arbiter outputs; carries no functional logic.
module mux8x1_rr_arbiter_chk #(
  parameter int HOLD_MAX = 4
) (
  input logic       clk,
  input logic       rst_n,
  input logic [7:0] req,
  input logic [7:0] in,
  input logic       ack,
  input logic [7:0] gnt,
  input logic [2:0] sel,
  input logic       result,
  input logic       valid,
  input logic       busy
);

  localparam bit HOLD_OK = (HOLD_MAX >= 1) && (HOLD_MAX <= 255);

  a_hold_range:   assert property (@(posedge clk) HOLD_OK);
  a_gnt_onehot:   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_gnt_busy:     assert property (@(posedge clk) disable iff (!rst_n) busy |-> (gnt == (8'h01 << sel)));
  a_gnt_idle:     assert property (@(posedge clk) disable iff (!rst_n) !busy |-> (gnt == 8'h00));
  a_valid_def:    assert property (@(posedge clk) disable iff (!rst_n) valid == (busy & req[sel]));
  a_result_def:   assert property (@(posedge clk) disable iff (!rst_n) result == (valid & in[sel]));
  a_beat_busy:    assert property (@(posedge clk) disable iff (!rst_n) (valid & ack) |-> busy);

endmodule

// File: tb/tb_mux8x1_rr_arbiter.sv
// Directed self-checking bench for mux8x1_rr_arbiter; hold-limit tests run when MUX8X1_ARB_HOLD_EN is defined.
module tb_mux8x1_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] in;
  logic       ack;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       result;
  logic       valid;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux8x1_rr_arbiter #(.HOLD_MAX(4)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .in     (in),
    .ack    (ack),
    .gnt    (gnt),
    .sel    (sel),
    .result (result),
    .valid  (valid),
    .busy   (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    req   = 8'h00;
    ack   = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req = 8'hFF; ack = 1'b1; in = 8'hAA;
    tick(); tick();
    n_cmp++; if (gnt !== 8'h00) begin $display("FAIL reset_gnt: got %0h expected 00", gnt); n_bad++; end
    n_cmp++; if (sel !== 3'd0) begin $display("FAIL reset_sel: got %0d expected 0", sel); n_bad++; end
    n_cmp++; if (valid !== 1'b0) begin $display("FAIL reset_valid: got %0b expected 0", valid); n_bad++; end
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %0b expected 0", busy); n_bad++; end
    n_cmp++; if (result !== 1'b0) begin $display("FAIL reset_result: got %0b expected 0", result); n_bad++; end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (gnt !== 8'h01) begin $display("FAIL reset_first_gnt: got %0h expected 01", gnt); n_bad++; end
    n_cmp++; if (busy !== 1'b1) begin $display("FAIL reset_first_busy: got %0b expected 1", busy); n_bad++; end
  endtask

  task automatic test_single;
    apply_reset();
    req = 8'h08; in = 8'b1010_1010; ack = 1'b1;
    tick();
    n_cmp++; if (sel !== 3'd3) begin $display("FAIL single_sel: got %0d expected 3", sel); n_bad++; end
    n_cmp++; if (gnt !== 8'h08) begin $display("FAIL single_gnt: got %0h expected 08", gnt); n_bad++; end
    n_cmp++; if (result !== 1'b1) begin $display("FAIL single_result: got %0b expected 1", result); n_bad++; end
    n_cmp++; if (valid !== 1'b1) begin $display("FAIL single_valid: got %0b expected 1", valid); n_bad++; end
    req = 8'h00;
    #1;
    n_cmp++; if (valid !== 1'b0) begin $display("FAIL single_drop_valid: got %0b expected 0", valid); n_bad++; end
    n_cmp++; if (result !== 1'b0) begin $display("FAIL single_drop_result: got %0b expected 0", result); n_bad++; end
    tick();
    n_cmp++; if (gnt !== 8'h00) begin $display("FAIL single_idle_gnt: got %0h expected 00", gnt); n_bad++; end
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL single_idle_busy: got %0b expected 0", busy); n_bad++; end
  endtask

  // Each step releases the current owner by dropping only its request bit.
  task automatic test_rotation;
    logic [2:0] e;
    logic [7:0] eg;
    apply_reset();
    req = 8'hFF; in = 8'b1010_1010; ack = 1'b1;
    tick();
    for (int k = 0; k < 9; k++) begin
      e  = 3'(k);
      eg = 8'h01 << e;
      n_cmp++; if (sel !== e) begin $display("FAIL rot_sel[%0d]: got %0d expected %0d", k, sel, e); n_bad++; end
      n_cmp++; if (gnt !== eg) begin $display("FAIL rot_gnt[%0d]: got %0h expected %0h", k, gnt, eg); n_bad++; end
      n_cmp++; if (result !== e[0]) begin $display("FAIL rot_result[%0d]: got %0b expected %0b", k, result, e[0]); n_bad++; end
      if (k < 8) begin
        req = ~eg;
        tick();
        req = 8'hFF;
        #1;
      end
    end
  endtask

`ifdef MUX8X1_ARB_HOLD_EN
  task automatic test_hold;
    logic [2:0] e;
    apply_reset();
    req = 8'h81; in = 8'b1010_1010; ack = 1'b1;
    tick();
    for (int j = 0; j < 12; j++) begin
      e = (((j / 4) % 2) == 1) ? 3'd7 : 3'd0;
      n_cmp++; if (sel !== e) begin $display("FAIL hold_sel[%0d]: got %0d expected %0d", j, sel, e); n_bad++; end
      n_cmp++; if (result !== e[0]) begin $display("FAIL hold_result[%0d]: got %0b expected %0b", j, result, e[0]); n_bad++; end
      if (j < 11) tick();
    end
    ack = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick();
      n_cmp++; if (sel !== 3'd0) begin $display("FAIL hold_frozen_sel[%0d]: got %0d expected 0", j, sel); n_bad++; end
    end
    ack = 1'b1;
    tick();
    n_cmp++; if (sel !== 3'd7) begin $display("FAIL hold_resume_sel: got %0d expected 7", sel); n_bad++; end
  endtask
`else
  task automatic test_macro_off;
    apply_reset();
    req = 8'h03; in = 8'b1010_1010; ack = 1'b1;
    tick();
    for (int j = 0; j < 20; j++) begin
      n_cmp++; if (sel !== 3'd0) begin $display("FAIL off_sel[%0d]: got %0d expected 0", j, sel); n_bad++; end
      tick();
    end
    req = 8'h02;
    #1;
    n_cmp++; if (valid !== 1'b0) begin $display("FAIL off_drop_valid: got %0b expected 0", valid); n_bad++; end
    tick();
    n_cmp++; if (sel !== 3'd1) begin $display("FAIL off_handover_sel: got %0d expected 1", sel); n_bad++; end
    n_cmp++; if (busy !== 1'b1) begin $display("FAIL off_handover_busy: got %0b expected 1", busy); n_bad++; end
    n_cmp++; if (gnt !== 8'h02) begin $display("FAIL off_handover_gnt: got %0h expected 02", gnt); n_bad++; end
    n_cmp++; if (result !== 1'b1) begin $display("FAIL off_handover_result: got %0b expected 1", result); n_bad++; end
  endtask
`endif

  // Leaves the pointer at 6 during a grant on 5 so a missed pointer reset would pick 6 afterwards.
  task automatic test_mid_reset;
    apply_reset();
    ack = 1'b1; in = 8'b1010_1010;
    req = 8'h20;
    tick();
    n_cmp++; if (sel !== 3'd5) begin $display("FAIL mid_first_sel: got %0d expected 5", sel); n_bad++; end
    req = 8'h00;
    tick();
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL mid_idle_busy: got %0b expected 0", busy); n_bad++; end
    req = 8'h20;
    tick();
    n_cmp++; if (sel !== 3'd5) begin $display("FAIL mid_regrant_sel: got %0d expected 5", sel); n_bad++; end
    req = 8'h60;
    tick();
    n_cmp++; if (sel !== 3'd5) begin $display("FAIL mid_nopreempt_sel: got %0d expected 5", sel); n_bad++; end
    rst_n = 1'b0;
    tick();
    n_cmp++; if (gnt !== 8'h00) begin $display("FAIL mid_rst_gnt: got %0h expected 00", gnt); n_bad++; end
    n_cmp++; if (sel !== 3'd0) begin $display("FAIL mid_rst_sel: got %0d expected 0", sel); n_bad++; end
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL mid_rst_busy: got %0b expected 0", busy); n_bad++; end
    n_cmp++; if (valid !== 1'b0) begin $display("FAIL mid_rst_valid: got %0b expected 0", valid); n_bad++; end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (sel !== 3'd5) begin $display("FAIL mid_after_sel: got %0d expected 5", sel); n_bad++; end
    n_cmp++; if (gnt !== 8'h20) begin $display("FAIL mid_after_gnt: got %0h expected 20", gnt); n_bad++; end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    in    = 8'h00;
    ack   = 1'b0;
    test_reset();
    test_single();
    test_rotation();
`ifdef MUX8X1_ARB_HOLD_EN
    test_hold();
`else
    test_macro_off();
`endif
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
